// File: rtl/rv32i_types.sv
// Shared fetch-path types: the queue packet, the fetch FSM encoding and the reset PC.
package rv32i_types;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h1eceb000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        DROP
    } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction queue: power-of-two circular buffer of fetch packets with a synchronous flush.
module fetch_fifo
    import rv32i_types::*;
#(
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       flush,
    input  logic       enq,
    input  fetch_pkt_t enq_data,
    input  logic       deq,
    output logic       valid,
    output fetch_pkt_t head,
    output logic [AW:0] count
);

    fetch_pkt_t  mem [DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic        do_deq;

    // The extra MSB on each pointer separates full (MSBs differ) from empty (equal).
    assign count  = wr_ptr - rd_ptr;
    assign valid  = (wr_ptr != rd_ptr);
    assign head   = mem[rd_ptr[AW-1:0]];
    assign do_deq = deq && valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (enq)    wr_ptr <= wr_ptr + 1'b1;
            if (do_deq) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq && !flush) mem[wr_ptr[AW-1:0]] <= enq_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// In-order instruction fetch: one outstanding I-cache request, credit-limited queue, redirect flush.
module fetch_unit
    import rv32i_types::*;
#(
    parameter int          QUEUE_DEPTH = 16,
    parameter logic [31:0] RESET_PC    = RESET_PC_DEFAULT
) (
    input  logic                           clk,
    input  logic                           rst,
    output logic [31:0]                    imem_addr,
    output logic [3:0]                     imem_rmask,
    input  logic [31:0]                    imem_rdata,
    input  logic                           imem_resp,
    input  logic                           redirect_valid,
    input  logic [31:0]                    redirect_pc,
    output logic                           fetch_valid,
    output logic [31:0]                    fetch_inst,
    output logic [31:0]                    fetch_pc,
    input  logic                           fetch_deq,
    output logic [$clog2(QUEUE_DEPTH):0]   fetch_count
);

    localparam int CW = $clog2(QUEUE_DEPTH) + 1;

    fetch_state_t state;
    logic [31:0]  pc;
    logic [31:0]  req_pc;
    logic         issue;
    logic         enq;
    fetch_pkt_t   enq_pkt;
    fetch_pkt_t   head;

    // IDLE means nothing outstanding, so occupancy alone is the credit check.
    // The strobe is combinational so a same-cycle redirect can suppress it.
    assign issue      = !rst && (state == IDLE) && !redirect_valid
                        && (fetch_count < CW'(QUEUE_DEPTH));
    assign enq        = (state == WAIT) && imem_resp && !redirect_valid;
    assign imem_rmask = issue ? 4'hF : 4'h0;
    // req_pc keeps the address stable in DROP even after pc has been redirected.
    assign imem_addr  = (state == IDLE) ? pc : req_pc;
    assign enq_pkt    = '{pc: req_pc, inst: imem_rdata};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            req_pc <= RESET_PC;
        end else if (redirect_valid) begin
            pc    <= redirect_pc;
            state <= (state != IDLE && !imem_resp) ? DROP : IDLE;
        end else begin
            case (state)
                IDLE: if (issue) begin
                    req_pc <= pc;
                    state  <= WAIT;
                end
                WAIT: if (imem_resp) begin
                    pc    <= pc + 32'd4;
                    state <= IDLE;
                end
                DROP: if (imem_resp) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    fetch_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .flush    (redirect_valid),
        .enq      (enq),
        .enq_data (enq_pkt),
        .deq      (fetch_deq),
        .valid    (fetch_valid),
        .head     (head),
        .count    (fetch_count)
    );

    assign fetch_inst = head.inst;
    assign fetch_pc   = head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit (QUEUE_DEPTH=4) with a fixed-latency I-cache responder.
module tb_fetch_unit;

    localparam logic [31:0] RPC = 32'h1eceb000;

    logic        clk = 0;
    logic        rst = 1;
    logic [31:0] imem_addr;
    logic [3:0]  imem_rmask;
    logic [31:0] imem_rdata = '0;
    logic        imem_resp = 0;
    logic        redirect_valid = 0;
    logic [31:0] redirect_pc = '0;
    logic        fetch_valid;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic        fetch_deq = 0;
    logic [2:0]  fetch_count;

    int checks = 0;
    int passes = 0;
    int lat = 1;
    int proto_err = 0;
    int req_total = 0;
    int handled = 0;
    int cnt = 0;
    int base = 0;
    logic        pend = 0;
    logic [31:0] pend_addr = '0;
    logic [31:0] last_addr = '0;
    logic [31:0] issued [$];

    fetch_unit #(.QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp), .redirect_valid(redirect_valid),
        .redirect_pc(redirect_pc), .fetch_valid(fetch_valid), .fetch_inst(fetch_inst),
        .fetch_pc(fetch_pc), .fetch_deq(fetch_deq), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] inst_of(input logic [31:0] a);
        return a ^ 32'hdeadbeef;
    endfunction

    // Request monitor: records every issued address and protocol violations.
    always @(negedge clk) begin
        if (!rst && imem_rmask == 4'hF) begin
            if (pend || imem_resp) proto_err++;
            req_total++;
            last_addr = imem_addr;
            issued.push_back(imem_addr);
        end
    end

    // Cache responder: answers each request lat cycles after it was issued.
    always @(posedge clk) begin
        #1;
        imem_resp = 0;
        if (rst) begin
            pend = 0;
            handled = req_total;
        end else begin
            if (handled != req_total) begin
                handled = req_total;
                pend = 1;
                pend_addr = last_addr;
                cnt = lat;
            end
            if (pend) begin
                if (cnt <= 1) begin
                    imem_resp = 1;
                    imem_rdata = inst_of(pend_addr);
                    pend = 0;
                end else cnt--;
            end
        end
    end

    task automatic tick();
        @(posedge clk); #2;
    endtask

    task automatic do_reset(input int l);
        rst = 1; fetch_deq = 0; redirect_valid = 0; redirect_pc = '0; lat = l;
        tick(); tick();
        base = issued.size();
        rst = 0;
    endtask

    task automatic test_reset();
        rst = 1;
        tick(); #1;
        checks++; if (fetch_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", fetch_valid); else passes++;
        checks++; if (fetch_count !== 3'd0) $display("FAIL reset_count: got %0d want 0", fetch_count); else passes++;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL reset_rmask: got %h want 0", imem_rmask); else passes++;
        checks++; if (imem_addr !== RPC) $display("FAIL reset_addr: got %h want %h", imem_addr, RPC); else passes++;
    endtask

    task automatic test_order_fill();
        do_reset(1);
        for (int i = 0; i < 40 && fetch_count != 3'd4; i++) tick();
        checks++; if (fetch_count !== 3'd4) $display("FAIL fill_count: got %0d want 4", fetch_count); else passes++;
        repeat (6) tick();
        checks++; if (issued.size() - base !== 4) $display("FAIL fill_reqs: got %0d want 4", issued.size() - base); else passes++;
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (issued[base+k] !== RPC + 32'(4*k)) $display("FAIL req_order%0d: got %h want %h", k, issued[base+k], RPC + 32'(4*k));
            else passes++;
        end
        #1;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL full_rmask: got %h want 0", imem_rmask); else passes++;
        checks++; if (fetch_pc !== RPC || fetch_inst !== inst_of(RPC)) $display("FAIL head0: got %h/%h want %h/%h", fetch_pc, fetch_inst, RPC, inst_of(RPC)); else passes++;
        fetch_deq = 1; tick(); fetch_deq = 0;
        repeat (6) tick();
        checks++; if (issued.size() - base !== 5) $display("FAIL refill_reqs: got %0d want 5", issued.size() - base); else passes++;
        checks++; if (issued[base+4] !== RPC + 32'h10) $display("FAIL refill_addr: got %h want %h", issued[base+4], RPC + 32'h10); else passes++;
        checks++; if (fetch_count !== 3'd4) $display("FAIL refill_count: got %0d want 4", fetch_count); else passes++;
        for (int k = 1; k < 4; k++) begin
            checks++;
            if (fetch_valid !== 1'b1 || fetch_pc !== RPC + 32'(4*k) || fetch_inst !== inst_of(RPC + 32'(4*k)))
                $display("FAIL drain%0d: got v=%b %h/%h want %h", k, fetch_valid, fetch_pc, fetch_inst, RPC + 32'(4*k));
            else passes++;
            fetch_deq = 1; tick();
        end
        fetch_deq = 0;
    endtask

    task automatic test_redirect_wait();
        do_reset(3); #1;
        checks++; if (imem_rmask !== 4'hF || imem_addr !== RPC) $display("FAIL first_req: got %h@%h want f@%h", imem_rmask, imem_addr, RPC); else passes++;
        tick();
        redirect_valid = 1; redirect_pc = 32'h1eceb100; #1;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL redir_rmask: got %h want 0", imem_rmask); else passes++;
        tick(); redirect_valid = 0;
        for (int i = 0; i < 10 && !imem_resp; i++) tick();
        checks++; if (imem_resp !== 1'b1) $display("FAIL drop_resp_seen: got %b want 1", imem_resp); else passes++;
        tick();
        checks++; if (fetch_count !== 3'd0 || fetch_valid !== 1'b0) $display("FAIL drop_count: got %0d/%b want 0/0", fetch_count, fetch_valid); else passes++;
        for (int i = 0; i < 10 && issued.size() - base < 2; i++) tick();
        checks++; if (issued[base+1] !== 32'h1eceb100) $display("FAIL redir_addr: got %h want 1eceb100", issued[base+1]); else passes++;
        for (int i = 0; i < 10 && !fetch_valid; i++) tick();
        checks++; if (fetch_pc !== 32'h1eceb100 || fetch_inst !== inst_of(32'h1eceb100)) $display("FAIL redir_head: got %h/%h want 1eceb100", fetch_pc, fetch_inst); else passes++;
    endtask

    task automatic test_redirect_resp_deq();
        int n0;
        do_reset(1);
        for (int i = 0; i < 20 && !(imem_resp && fetch_count != 0); i++) tick();
        checks++; if (!(imem_resp && fetch_count != 0)) $display("FAIL rrd_setup: got resp=%b cnt=%0d want 1/>0", imem_resp, fetch_count); else passes++;
        n0 = issued.size();
        redirect_valid = 1; redirect_pc = 32'h1eceb200; fetch_deq = 1; #1;
        checks++; if (imem_rmask !== 4'h0) $display("FAIL rrd_rmask: got %h want 0", imem_rmask); else passes++;
        tick(); redirect_valid = 0; fetch_deq = 0;
        checks++; if (fetch_count !== 3'd0 || fetch_valid !== 1'b0) $display("FAIL rrd_flush: got %0d/%b want 0/0", fetch_count, fetch_valid); else passes++;
        for (int i = 0; i < 10 && issued.size() <= n0; i++) tick();
        checks++; if (issued[n0] !== 32'h1eceb200) $display("FAIL rrd_addr: got %h want 1eceb200", issued[n0]); else passes++;
        for (int i = 0; i < 10 && !fetch_valid; i++) tick();
        checks++; if (fetch_pc !== 32'h1eceb200) $display("FAIL rrd_head: got %h want 1eceb200", fetch_pc); else passes++;
    endtask

    task automatic test_back_to_back();
        logic [31:0] exp;
        do_reset(1);
        for (int i = 0; i < 20 && fetch_count != 3'd2; i++) tick();
        checks++; if (fetch_count !== 3'd2) $display("FAIL b2b_setup: got %0d want 2", fetch_count); else passes++;
        exp = RPC;
        for (int k = 0; k < 12; k++) begin
            for (int i = 0; i < 6 && !imem_resp; i++) tick();
            checks++;
            if (fetch_count !== 3'd2 || fetch_pc !== exp || fetch_inst !== inst_of(exp))
                $display("FAIL b2b_head%0d: got cnt=%0d %h/%h want 2 %h", k, fetch_count, fetch_pc, fetch_inst, exp);
            else passes++;
            fetch_deq = 1; tick(); fetch_deq = 0;
            checks++; if (fetch_count !== 3'd2) $display("FAIL b2b_count%0d: got %0d want 2", k, fetch_count); else passes++;
            exp = exp + 32'd4;
        end
    endtask

    task automatic test_async_reset();
        do_reset(1);
        for (int i = 0; i < 20 && fetch_count != 3'd2; i++) tick();
        tick();
        checks++; if (imem_addr !== RPC + 32'h8) $display("FAIL ar_pre_addr: got %h want %h", imem_addr, RPC + 32'h8); else passes++;
        #1 rst = 1; #1;
        checks++; if (imem_rmask !== 4'h0 || imem_addr !== RPC) $display("FAIL ar_req: got %h@%h want 0@%h", imem_rmask, imem_addr, RPC); else passes++;
        checks++; if (fetch_valid !== 1'b0 || fetch_count !== 3'd0) $display("FAIL ar_queue: got %b/%0d want 0/0", fetch_valid, fetch_count); else passes++;
        tick();
        base = issued.size();
        rst = 0;
        for (int i = 0; i < 5 && issued.size() == base; i++) tick();
        checks++; if (issued[base] !== RPC) $display("FAIL ar_first: got %h want %h", issued[base], RPC); else passes++;
    endtask

    initial begin
        test_reset();
        test_order_fill();
        test_redirect_wait();
        test_redirect_resp_deq();
        test_back_to_back();
        test_async_reset();
        repeat (4) tick();
        checks++; if (proto_err !== 0) $display("FAIL protocol: got %0d violations want 0", proto_err); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
